outputc: RTL and testbench

// - Router output channel: transmit end of the link that an input controller

---
 rtl/outputc_pkg.sv | 30 +++
 rtl/outputc_if.sv | 28 ++
 rtl/outputc_rr_arb5.sv | 38 +++
 rtl/outputc.sv | 117 +++++++++++
 tb/tb_outputc.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/outputc_pkg.sv
// Shared link constants, flit type encodings and FSM states for the router output channel.
package outputc_pkg;

  localparam int DATAW    = 31;
  localparam int VCHW     = 0;
  localparam int VCH      = 0;
  localparam int PORTW    = 2;
  localparam int N_PORT   = 5;
  localparam int TYPE_MSB = 31;
  localparam int TYPE_LSB = 30;

  typedef enum logic [1:0] {
    TYPE_BODY     = 2'b00,
    TYPE_HEAD     = 2'b01,
    TYPE_TAIL     = 2'b10,
    TYPE_HEADTAIL = 2'b11
  } flit_type_e;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  typedef logic [2:0] port_idx_t;

  function automatic logic is_tail(input logic [1:0] ftype);
    return (ftype == TYPE_TAIL) || (ftype == TYPE_HEADTAIL);
  endfunction

endpackage

// File: rtl/outputc_if.sv
// Bundle between the five input controllers, this output channel and the downstream link.
interface outputc_if;
  import outputc_pkg::*;

  logic [N_PORT-1:0]            req;
  logic [N_PORT-1:0][PORTW:0]   port;
  logic [N_PORT-1:0]            grt;
  logic [N_PORT-1:0][DATAW:0]   idata;
  logic [N_PORT-1:0]            ivalid;
  logic [N_PORT-1:0][VCHW:0]    ivch;
  logic [DATAW:0]               odata;
  logic                         ovalid;
  logic [VCHW:0]                ovch;
  logic [VCH:0]                 iack;
  logic [VCH:0]                 ordy;
  logic [VCH:0]                 olck;

  modport master (
    output req, port, idata, ivalid, ivch, iack,
    input  grt, odata, ovalid, ovch, ordy, olck
  );

  modport slave (
    input  req, port, idata, ivalid, ivch, iack,
    output grt, odata, ovalid, ovch, ordy, olck
  );

endinterface

// File: rtl/outputc_rr_arb5.sv
// Five-way round-robin arbiter: combinational one-hot grant, pointer holds the last winner.
module rr_arb5
  import outputc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_,
  input  logic [N_PORT-1:0] req,
  input  logic              en,
  output logic [N_PORT-1:0] grant,
  output port_idx_t         winner
);

  port_idx_t ptr;
  port_idx_t idx;

  // NOTE: every output gets a default before the loop so no path leaves a latch behind.
  always_comb begin
    grant  = '0;
    winner = ptr;
    idx    = ptr;
    // Walk downward so the closest requester after ptr is the last (winning) assignment.
    for (int i = N_PORT; i >= 1; i--) begin
      idx = port_idx_t'((int'(ptr) + i) % N_PORT);
      if (req[idx]) winner = idx;
    end
    if (|req) grant[winner] = 1'b1;
  end

  // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst_) begin
      ptr <= '0;
    end else if (en && (|req)) begin
      ptr <= winner;
    end
  end

endmodule

// File: rtl/outputc.sv
// Router output channel: arbitrates input controllers, locks to one packet, forwards flits
// to the downstream link and tracks downstream buffer space with credits.
module outputc
  import outputc_pkg::*;
#(
  parameter int ROUTERID  = 0,
  parameter int PORTID    = 0,
  parameter int BUF_DEPTH = 4,
  parameter int PKT_FLITS = 4
) (
  input logic      clk,
  input logic      rst_,
  outputc_if.slave bus
);

  localparam int             CW       = $clog2(BUF_DEPTH + 1);
  localparam logic [PORTW:0] PORT_SEL = (PORTW+1)'(PORTID);

  state_e            state;
  port_idx_t         owner;
  port_idx_t         arb_win;
  logic [N_PORT-1:0] vreq;
  logic [N_PORT-1:0] arb_grant;
  logic [N_PORT-1:0] grt_q;
  logic              olck_q;
  logic [DATAW:0]    odata_q;
  logic              ovalid_q;
  logic [VCHW:0]     ovch_q;
  logic [CW-1:0]     credit;
  logic              ordy;
  logic              arb_en;
  logic              fwd;
  logic              tail;

  always_comb begin
    vreq = '0;
    for (int n = 0; n < N_PORT; n++) begin
      vreq[n] = bus.req[n] && (bus.port[n] == PORT_SEL);
    end
  end

  // Only start a packet when the downstream buffer can absorb a full-length one.
  assign ordy   = (int'(credit) >= PKT_FLITS);
  assign arb_en = (state == IDLE) && ordy && (|vreq);
  assign fwd    = (state == LOCKED) && bus.ivalid[owner];
  assign tail   = is_tail(bus.idata[owner][TYPE_MSB:TYPE_LSB]);

  rr_arb5 u_arb (
    .clk    (clk),
    .rst_   (rst_),
    .req    (vreq),
    .en     (arb_en),
    .grant  (arb_grant),
    .winner (arb_win)
  );

  always_ff @(posedge clk) begin
    if (rst_) begin
      state    <= IDLE;
      owner    <= '0;
      grt_q    <= '0;
      olck_q   <= 1'b0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      ovch_q   <= '0;
      credit   <= CW'(BUF_DEPTH);
    end else begin
      ovalid_q <= fwd;
      odata_q  <= fwd ? bus.idata[owner] : '0;
      ovch_q   <= fwd ? bus.ivch[owner]  : '0;

      case (state)
        IDLE: begin
          if (arb_en) begin
            state  <= LOCKED;
            owner  <= arb_win;
            grt_q  <= arb_grant;
            olck_q <= 1'b1;
          end
        end
        LOCKED: begin
          if (fwd && tail) begin
            state  <= IDLE;
            grt_q  <= '0;
            olck_q <= 1'b0;
          end
        end
      endcase

      // A credit is spent as the flit is launched and returned on each downstream pop.
      case ({fwd, bus.iack[0]})
        2'b10:   if (credit != '0) credit <= credit - CW'(1);
        2'b01:   if (credit != CW'(BUF_DEPTH)) credit <= credit + CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      assert (!(|(bus.ivalid & ~grt_q)))
        else $error("router %0d port %0d: stray flit dropped", ROUTERID, PORTID);
      assert (!(fwd && !bus.iack[0] && (credit == '0)))
        else $error("router %0d port %0d: credit underflow", ROUTERID, PORTID);
      assert (!(!fwd && bus.iack[0] && (credit == CW'(BUF_DEPTH))))
        else $error("router %0d port %0d: credit overflow", ROUTERID, PORTID);
    end
  end

  assign bus.grt    = grt_q;
  assign bus.odata  = odata_q;
  assign bus.ovalid = ovalid_q;
  assign bus.ovch   = ovch_q;
  assign bus.ordy   = ordy;
  assign bus.olck   = olck_q;

endmodule

// File: tb/tb_outputc.sv
// Randomized bench for outputc: packet-level input controllers and a downstream sink,
// compared every cycle against a transaction-level model of arbitration and credits.
module tb_outputc;
  import outputc_pkg::*;

  localparam int PORTID    = 2;
  localparam int BUF_DEPTH = 4;
  localparam int PKT_FLITS = 4;

  logic clk = 1'b0;
  logic rst_;
  always #5 clk = ~clk;

  outputc_if bus ();

  outputc #(
    .ROUTERID  (0),
    .PORTID    (PORTID),
    .BUF_DEPTH (BUF_DEPTH),
    .PKT_FLITS (PKT_FLITS)
  ) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Input controller packet state and stimulus knobs.
  int pend_len[N_PORT];
  int sent[N_PORT];
  int dest[N_PORT];
  bit refill[N_PORT];
  bit rand_mode = 1'b0;
  int vprob     = 100;
  int ack_mode  = 0;
  bit force_ack = 1'b0;
  bit r_rst     = 1'b1;

  // Reference model state.
  bit             m_busy   = 1'b0;
  int             m_owner  = 0;
  int             m_last   = 0;
  int             m_credit = BUF_DEPTH;
  bit             m_ovalid = 1'b0;
  logic [DATAW:0] m_odata  = '0;

  int                grant_log[$];
  logic [N_PORT-1:0] prev_grt = '0;
  int                seen_grt3 = 0;
  int                seen_ovalid = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] ftype(input int s, input int len);
    if (len == 1)     return TYPE_HEADTAIL;
    if (s == 0)       return TYPE_HEAD;
    if (s == len - 1) return TYPE_TAIL;
    return TYPE_BODY;
  endfunction

  task automatic step();
    logic [N_PORT-1:0]          req;
    logic [N_PORT-1:0]          iv;
    logic [N_PORT-1:0][PORTW:0] port;
    logic [N_PORT-1:0][DATAW:0] idata;
    logic [N_PORT-1:0]          eg;
    logic                       ack;
    int                         drv;
    int                         cb;
    int                         c;
    bit                         fwd;
    bit                         found;

    for (int n = 0; n < N_PORT; n++) begin
      if (refill[n] && pend_len[n] == 0) begin
        pend_len[n] = 1;
        dest[n]     = PORTID;
      end
      if (rand_mode) begin
        if (pend_len[n] == 0 && $urandom_range(9) == 0) begin
          pend_len[n] = int'($urandom_range(PKT_FLITS, 1));
          dest[n]     = ($urandom_range(4) == 0) ? int'($urandom_range(N_PORT - 1)) : PORTID;
        end else if (pend_len[n] > 0 && dest[n] != PORTID && $urandom_range(9) == 0) begin
          pend_len[n] = 0;
        end
      end
    end

    req = '0; iv = '0; port = '0; idata = '0; drv = -1;
    for (int n = 0; n < N_PORT; n++) begin
      req[n]  = (pend_len[n] > 0);
      port[n] = (PORTW+1)'(dest[n]);
    end
    if (!r_rst && m_busy && pend_len[m_owner] > 0 && int'($urandom_range(99)) < vprob) begin
      drv        = m_owner;
      iv[drv]    = 1'b1;
      idata[drv] = {ftype(sent[drv], pend_len[drv]), 30'($urandom)};
    end
    ack = force_ack ||
          (!r_rst && m_credit < BUF_DEPTH &&
           (ack_mode == 2 || (ack_mode == 1 && $urandom_range(1) == 1)));

    rst_       = r_rst;
    bus.req    = req;
    bus.port   = port;
    bus.ivalid = iv;
    bus.idata  = idata;
    bus.ivch   = '0;
    bus.iack   = ack;

    @(posedge clk);

    if (r_rst) begin
      m_busy = 1'b0; m_owner = 0; m_last = 0; m_credit = BUF_DEPTH;
      m_ovalid = 1'b0; m_odata = '0;
    end else begin
      fwd      = m_busy && (drv >= 0);
      m_ovalid = fwd;
      m_odata  = fwd ? idata[drv] : '0;
      cb       = m_credit;
      m_credit = m_credit - int'(fwd) + int'(ack);
      if (!m_busy) begin
        found = 1'b0;
        if (cb >= PKT_FLITS) begin
          for (int k = 1; k <= N_PORT; k++) begin
            c = (m_last + k) % N_PORT;
            if (!found && req[c] && dest[c] == PORTID) begin
              found = 1'b1; m_owner = c; m_last = c; m_busy = 1'b1;
            end
          end
        end
      end else if (fwd && sent[drv] + 1 == pend_len[drv]) begin
        m_busy = 1'b0;
      end
      if (drv >= 0) begin
        sent[drv]++;
        if (sent[drv] == pend_len[drv]) begin
          pend_len[drv] = 0;
          sent[drv]     = 0;
        end
      end
    end

    #1;
    eg = m_busy ? (N_PORT'(1) << m_owner) : '0;
    check("grt",    32'(bus.grt),    32'(eg));
    check("olck",   32'(bus.olck),   32'(m_busy));
    check("ovalid", 32'(bus.ovalid), 32'(m_ovalid));
    check("odata",  32'(bus.odata),  32'(m_odata));
    check("ovch",   32'(bus.ovch),   32'(0));
    check("ordy",   32'(bus.ordy),   32'(m_credit >= PKT_FLITS));
    check("credit", 32'(dut.credit), 32'(m_credit));

    if (bus.grt != '0 && prev_grt == '0) begin
      for (int n = 0; n < N_PORT; n++) if (bus.grt[n]) grant_log.push_back(n);
    end
    prev_grt = bus.grt;
    if (bus.grt[3]) seen_grt3++;
    if (bus.ovalid) seen_ovalid++;
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  initial begin
    for (int n = 0; n < N_PORT; n++) begin
      pend_len[n] = 0; sent[n] = 0; dest[n] = PORTID; refill[n] = 1'b0;
    end

    // Reset held for two cycles.
    r_rst = 1'b1;
    run(2);
    check("rst_grt",    32'(bus.grt),    32'(0));
    check("rst_ovalid", 32'(bus.ovalid), 32'(0));
    check("rst_credit", 32'(dut.credit), 32'(4));
    check("rst_ordy",   32'(bus.ordy),   32'(1));
    r_rst = 1'b0;

    // Single 4-flit packet from input 1 with no credit return.
    pend_len[1] = 4; dest[1] = PORTID;
    run(8);
    check("single_done",   32'(pend_len[1]), 32'(0));
    check("single_credit", 32'(dut.credit),  32'(0));
    check("single_ordy",   32'(bus.ordy),    32'(0));
    check("single_olck",   32'(bus.olck),    32'(0));

    // Credit stall, single return, then release with acks overlapping flits.
    pend_len[2] = 4; dest[2] = PORTID;
    run(3);
    check("stall_grt", 32'(bus.grt), 32'(0));
    force_ack = 1'b1;
    run(1);
    force_ack = 1'b0;
    check("one_ack_credit", 32'(dut.credit), 32'(1));
    check("one_ack_grt",    32'(bus.grt),    32'(0));
    ack_mode = 2;
    run(12);
    check("release_done",   32'(pend_len[2]), 32'(0));
    check("release_credit", 32'(dut.credit),  32'(4));

    // Three-way contention with back-to-back HEADTAIL packets.
    grant_log.delete();
    refill[0] = 1'b1; refill[2] = 1'b1; refill[4] = 1'b1;
    run(30);
    refill[0] = 1'b0; refill[2] = 1'b0; refill[4] = 1'b0;
    run(8);
    check("cont_count", 32'(grant_log.size() >= 6), 32'(1));
    for (int i = 0; i < grant_log.size(); i++) begin
      check("cont_member", 32'(grant_log[i] % 2), 32'(0));
      if (i + 1 < grant_log.size()) check("cont_rot1", 32'(grant_log[i] != grant_log[i+1]), 32'(1));
      if (i + 2 < grant_log.size()) check("cont_rot2", 32'(grant_log[i] != grant_log[i+2]), 32'(1));
    end

    // Request for another port is filtered out.
    seen_grt3 = 0; seen_ovalid = 0;
    pend_len[3] = 2; dest[3] = (PORTID + 1) % N_PORT;
    run(10);
    check("filter_grt3",   32'(seen_grt3),   32'(0));
    check("filter_ovalid", 32'(seen_ovalid), 32'(0));
    pend_len[3] = 0;

    // Reset after the second flit abandons the packet.
    pend_len[1] = 4; dest[1] = PORTID;
    for (int k = 0; k < 12 && sent[1] < 2; k++) step();
    check("mid_sent", 32'(sent[1]), 32'(2));
    r_rst = 1'b1;
    pend_len[1] = 0; sent[1] = 0;
    run(1);
    r_rst = 1'b0;
    check("mid_grt",    32'(bus.grt),    32'(0));
    check("mid_olck",   32'(bus.olck),   32'(0));
    check("mid_ovalid", 32'(bus.ovalid), 32'(0));
    check("mid_credit", 32'(dut.credit), 32'(4));
    grant_log.delete();
    pend_len[0] = 2; dest[0] = PORTID;
    run(8);
    check("post_rst_done",  32'(pend_len[0]),       32'(0));
    check("post_rst_owner", 32'(grant_log.size() == 1 && grant_log[0] == 0), 32'(1));

    // Randomized traffic with bubbles and random credit return.
    rand_mode = 1'b1; vprob = 70; ack_mode = 1;
    run(2000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
